// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, with a
// one-entry response register tagged by the owning requester id.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags
);

  logic last_grant;
  logic slot_free;
  logic grant0;
  logic grant1;
  logic xfer;

  assign slot_free = !rsp_valid || rsp_ready;

  // Gated by rst so nothing is offered to the requesters while reset is held.
  assign grant0 = rst && slot_free && req0_valid && (!req1_valid || last_grant);
  assign grant1 = rst && slot_free && req1_valid && (!req0_valid || !last_grant);
  assign xfer   = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    if (rst) begin
      if (grant1) begin
        alu_a    = req1_a;
        alu_b    = req1_b;
        alu_ctrl = req1_ctrl;
      end else begin
        alu_a    = req0_a;
        alu_b    = req0_b;
        alu_ctrl = req0_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= grant1;
      rsp_result <= alu_result;
      rsp_flags  <= alu_flags;
      last_grant <= grant1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: attached ALU model, directed scenarios with
// literal expectations, then randomized traffic against a transaction-level model.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl, alu_flags;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  int total = 0;
  int bad   = 0;

  // model state: pending response and who was served last
  logic        m_valid, m_id, m_last;
  logic [31:0] m_res;
  logic [3:0]  m_flags;
  logic        acc0, acc1;
  logic [3:0]  saved_flags;

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, else pass A; flags {V,C,Z,N}
  function automatic logic [35:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic        cf, vf;
    w  = '0;
    cf = 1'b0;
    vf = 1'b0;
    case (c)
      4'd0: begin
        w  = {1'b0, a} + {1'b0, b};
        r  = w[31:0];
        cf = w[32];
        vf = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin
        r  = a - b;
        cf = a < b;
        vf = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = {31'd0, $signed(a) < $signed(b)};
      default: r = a;
    endcase
    return {vf, cf, (r == 32'd0), r[31], r};
  endfunction

  assign {alu_flags, alu_result} = alu_fn(alu_ctrl, alu_a, alu_b);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every negedge, outputs vs. the transaction-level model.
  always @(negedge clk) begin
    logic        free, w0, w1;
    logic [35:0] op;
    if (!rst) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_alu", {alu_a, alu_b, alu_ctrl}, 0);
      chk("rst_rsp", {rsp_valid, rsp_id, rsp_result, rsp_flags}, 0);
      m_valid = 1'b0; m_id = 1'b0; m_res = '0; m_flags = '0; m_last = 1'b1;
      acc0 = 1'b0; acc1 = 1'b0;
    end else begin
      free = !m_valid || rsp_ready;
      // one candidate wins outright; two candidates: the one not served last
      w0 = free && req0_valid && (!req1_valid || m_last == 1'b1);
      w1 = free && req1_valid && (!req0_valid || m_last == 1'b0);
      chk("ready0", req0_ready, w0);
      chk("ready1", req1_ready, w1);
      chk("alu_drive", {alu_a, alu_b, alu_ctrl},
          w1 ? {req1_a, req1_b, req1_ctrl} : {req0_a, req0_b, req0_ctrl});
      chk("rsp_valid", rsp_valid, m_valid);
      chk("rsp_data", {rsp_id, rsp_result, rsp_flags}, {m_id, m_res, m_flags});
      if (w0 || w1) begin
        op      = w1 ? alu_fn(req1_ctrl, req1_a, req1_b) : alu_fn(req0_ctrl, req0_a, req0_b);
        m_valid = 1'b1;
        m_id    = w1;
        m_last  = w1;
        m_res   = op[31:0];
        m_flags = op[35:32];
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
      acc0 = w0;
      acc1 = w1;
    end
  end

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_low();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_operand();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 3));
    return $urandom();
  endfunction

  initial begin
    rst = 1'b0;
    rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_ctrl = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_ctrl = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    mid_low();
    chk("reset_rsp_valid", rsp_valid, 0);
    after_edge();
    rst = 1'b1;

    // lone req0 ADD 5+7
    after_edge();
    req0_valid = 1'b1; req0_ctrl = 4'd0; req0_a = 32'd5; req0_b = 32'd7;
    rsp_ready = 1'b1;
    mid_low();
    chk("add_ready0", req0_ready, 1);
    after_edge();
    req0_valid = 1'b0;
    mid_low();
    chk("add_rsp", {rsp_valid, rsp_id, rsp_result, rsp_flags}, {1'b1, 1'b0, 32'd12, 4'b0000});

    // req1 alone for four ops
    for (int i = 0; i < 4; i++) begin
      after_edge();
      req1_valid = 1'b1; req1_ctrl = 4'd0; req1_a = 32'(i); req1_b = 32'd1;
      mid_low();
      chk("solo1_ready", req1_ready, 1);
    end

    // both valid: grants alternate starting with req0
    after_edge();
    req0_valid = 1'b1; req0_ctrl = 4'd1; req0_a = 32'd3;    req0_b = 32'd3;
    req1_valid = 1'b1; req1_ctrl = 4'd4; req1_a = 32'hF0;   req1_b = 32'h0F;
    for (int i = 0; i < 4; i++) begin
      mid_low();
      chk("alt_ready0", req0_ready, (i % 2) == 0);
      chk("alt_ready1", req1_ready, (i % 2) == 1);
      if (i > 0) begin
        chk("alt_rsp_id", rsp_id, (i - 1) % 2);
        chk("alt_rsp", {rsp_result, rsp_flags},
            ((i - 1) % 2) ? {32'hFF, 4'b0000} : {32'h0, 4'b0010});
      end
      after_edge();
      if (i == 3) rsp_ready = 1'b0;
    end

    // backpressure: held response stays put, no grants
    for (int j = 0; j < 3; j++) begin
      mid_low();
      chk("bp_ready", {req0_ready, req1_ready}, 2'b00);
      chk("bp_rsp", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b1, 32'hFF});
      after_edge();
      if (j == 2) rsp_ready = 1'b1;
    end
    mid_low();
    chk("bp_release", {req0_ready, req1_ready}, 2'b10);

    // async reset while a response is pending
    after_edge();
    rsp_ready = 1'b0;
    #2;
    chk("pre_rst_valid", rsp_valid, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", rsp_valid, 0);
    chk("async_rst_ready", {req0_ready, req1_ready}, 2'b00);
    @(posedge clk);
    #3;
    rst = 1'b1;
    rsp_ready = 1'b1;
    mid_low();
    chk("post_rst_grant", {req0_ready, req1_ready}, 2'b10);
    after_edge();
    req0_valid = 1'b0;
    mid_low();
    chk("post_rst_req1", req1_ready, 1);

    // SLT through the attached ALU
    after_edge();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_ctrl = 4'd5; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;
    mid_low();
    chk("slt_ready", req0_ready, 1);
    saved_flags = alu_flags;
    after_edge();
    req0_valid = 1'b0;
    mid_low();
    chk("slt_rsp", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 32'd1});
    chk("slt_flags_sampled", rsp_flags, saved_flags);
    chk("slt_flags", rsp_flags, 4'b0000);

    // randomized traffic; requests held until accepted
    for (int k = 0; k < 3000; k++) begin
      after_edge();
      if (acc0 || !req0_valid) begin
        req0_valid = $urandom_range(0, 2) != 0;
        req0_ctrl  = 4'($urandom_range(0, 7));
        req0_a     = rnd_operand();
        req0_b     = rnd_operand();
      end
      if (acc1 || !req1_valid) begin
        req1_valid = $urandom_range(0, 2) != 0;
        req1_ctrl  = 4'($urandom_range(0, 7));
        req1_a     = rnd_operand();
        req1_b     = rnd_operand();
      end
      rsp_ready = $urandom_range(0, 3) != 0;
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
